// File: rtl/instr_fetch_if.sv
// Fetch-side bundle for instr_fetch: instruction memory req/ack channel,
// held-word valid/ready channel and the decoder jump/flag inputs.
interface instr_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 18
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               instr_ready;
  logic [ADDR_W-1:0]  pc;
  logic               jump_valid;
  logic [2:0]         jump_sel;
  logic [5:0]         jump_off;
  logic               flag_carry;
  logic               flag_zero;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc,
    input  imem_ack, imem_data, instr_ready,
    input  jump_valid, jump_sel, jump_off, flag_carry, flag_zero
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc,
    output imem_ack, imem_data, instr_ready,
    output jump_valid, jump_sel, jump_off, flag_carry, flag_zero
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, fetches one word at a time over
// req/ack, holds it for the core and applies the decoder's relative jump.
module instr_fetch #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_r;
  logic               req_r;
  logic               valid_r;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pc_next_r;
  logic [INSTR_W-1:0] instr_r;
  logic               taken_s;
  logic [ADDR_W-1:0]  target_s;

  function automatic logic jump_taken(
    input logic       jv,
    input logic [2:0] sel,
    input logic       carry,
    input logic       zero
  );
    logic cond;
    case (sel)
      3'd0:    cond = 1'b0;
      3'd1:    cond = 1'b1;
      3'd2:    cond = carry;
      3'd3:    cond = ~carry;
      3'd4:    cond = zero;
      3'd5:    cond = ~zero;
      default: cond = 1'b0;
    endcase
    return jv & cond;
  endfunction

  // Successor address of the held word; only latched on the consuming cycle.
  always_comb begin
    taken_s  = jump_taken(bus.jump_valid, bus.jump_sel, bus.flag_carry, bus.flag_zero);
    target_s = pc_r + ADDR_W'(1);
    if (taken_s) begin
      target_s = pc_r + ADDR_W'(1) + {{(ADDR_W-6){bus.jump_off[5]}}, bus.jump_off};
    end else begin
      target_s = pc_r + ADDR_W'(1);
    end
  end

  // Fetch/hold sequencer; req_r stays low for the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FETCH;
      req_r     <= 1'b0;
      valid_r   <= 1'b0;
      pc_r      <= '0;
      pc_next_r <= '0;
      instr_r   <= '0;
    end else begin
      case (state_r)
        FETCH: begin
          if (req_r && bus.imem_ack) begin
            instr_r <= bus.imem_data;
            pc_r    <= pc_next_r;
            valid_r <= 1'b1;
            req_r   <= 1'b0;
            state_r <= HOLD;
          end else begin
            req_r   <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            pc_next_r <= target_s;
            valid_r   <= 1'b0;
            req_r     <= 1'b1;
            state_r   <= FETCH;
          end else begin
            valid_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= FETCH;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_r;
  assign bus.imem_addr   = pc_next_r;
  assign bus.instruction = instr_r;
  assign bus.instr_valid = valid_r;
  assign bus.pc          = pc_r;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that feeds the control unit. Owns the program counter. Reads 18-bit instruction words from instruction memory over a req/ack handshake and presents each word with a valid/ready handshake. Applies the conditional relative jump that the decoder reports for the word currently being consumed.

## Interface
- ADDR_W, 16, program counter and instruction memory address width
- INSTR_W, 18, instruction word width (fixed at 18 for the current ISA)

- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- o_imem_req  output  1  fetch request to instruction memory
- o_imem_addr  output  ADDR_W  fetch address
- i_imem_ack  input  1  memory returns data this cycle
- i_imem_data  input  INSTR_W  instruction word, valid when i_imem_ack=1
- o_instruction  output  INSTR_W  held instruction, wired to the decoder instruction input
- o_instr_valid  output  1  o_instruction is a fetched word awaiting consumption
- i_instr_ready  input  1  core consumes the held word this cycle
- o_pc  output  ADDR_W  address of the held word
- i_jump_valid  input  1  jump fields below are meaningful (decoder output for the held word)
- i_jump_sel  input  3  jump condition select
- i_jump_off  input  6  signed two's-complement jump offset
- i_flag_carry  input  1  carry flag from the ALU carry register
- i_flag_zero  input  1  zero flag from the ALU

## Operation
- FSM states: FETCH and HOLD. Reset state is FETCH.
- **FETCH**
  - o_imem_req=1. o_imem_addr=pc_next.
  - On i_imem_ack: capture i_imem_data into o_instruction, capture the fetch address into o_pc, go to HOLD.
- **HOLD**
  - o_instr_valid=1. o_imem_req=0.
  - On i_instr_ready: compute pc_next, go to FETCH.
  - Without i_instr_ready, o_instruction and o_pc hold indefinitely.
- **Jump conditions.** A jump is taken iff i_jump_valid=1 and the condition selected by i_jump_sel is true:
  - 0: never
  - 1: always
  - 2: carry=1
  - 3: carry=0
  - 4: zero=1
  - 5: zero=0
  - 6, 7: reserved, treated as never
- **Next PC.**
  - Taken: pc_next = o_pc + 1 + sign_extend(i_jump_off), computed modulo 2^ADDR_W.
  - Not taken: pc_next = o_pc + 1, modulo 2^ADDR_W.
  - Arithmetic wraps. 0xFFFF+1 gives 0x0000. 0x0000+1-32 gives 0xFFE1.
- **Sampling.** Jump fields and flags are sampled only in the HOLD cycle where i_instr_ready=1. They are ignored at all other times.
- **Reset values.**
  - o_imem_req=0, o_imem_addr=0.
  - o_instruction=0, o_instr_valid=0.
  - o_pc=0, internal pc_next=0.
  - State FETCH.
- **Reset mid-operation.** Asserting i_rst_n=0 at any point clears all state immediately and abandons any outstanding request. Instruction memory tolerates a dropped request.

## Timing
- o_imem_req is low while i_rst_n=0. It goes high in the first cycle after reset deassertion, with o_imem_addr=0.
- While o_imem_req=1, o_imem_addr is stable until the ack cycle.
- Ack may arrive in the same cycle req rises (zero-wait memory) or any number of cycles later.
- i_imem_ack while o_imem_req=0 is ignored and must not change state.
- Ack in cycle N: o_instr_valid=1 and o_instruction updated from cycle N+1.
- Consumption (valid & ready) in cycle M: o_instr_valid=0 and o_imem_req=1 with the new address from cycle M+1.
- Peak throughput: one instruction per 2 cycles with zero-wait memory and ready held high.
- All outputs are registered except o_imem_addr, which is driven from the registered pc_next.
- No combinational path from any input to any output.

## Test plan
- **Reset and sequential fetch.** Release reset, zero-wait ack, ready=1, words 0x00001,0x00002,0x00003 at addr 0,1,2, no jumps.
  - Expect o_imem_addr 0,1,2 on alternate cycles.
  - Expect o_instruction/o_pc pairs (0x00001,0), (0x00002,1), (0x00003,2), each valid exactly one cycle.
- **Wait states and backpressure.** Ack delayed 3 cycles, then ready held 0 for 4 cycles.
  - Expect addr stable through all wait cycles.
  - Expect o_instruction, o_pc and valid stable until ready=1.
  - Expect no second req before consumption.
- **Jump conditions.** Held word at pc=0x0010, i_jump_off=+5.
  - sel=1: next addr 0x0016.
  - sel=2 with carry=1: next addr 0x0016.
  - sel=2 with carry=0: next addr 0x0011.
  - sel=4/5 with zero=1: 0x0016 and 0x0011 respectively.
  - sel=6 and sel=7: 0x0011.
  - i_jump_valid=0 with sel=1: 0x0011.
- **Wrap-around.** pc=0xFFFF with no jump: next addr 0x0000. pc=0x0002 with sel=1 and off=-32 (0x20): next addr 0xFFE3.
- **Spurious ack and mid-fetch reset.**
  - Ack pulse in HOLD: no state change.
  - Assert i_rst_n=0 while req=1 and waiting for ack: req, valid and pc drop to 0 immediately.
  - After release, fetch restarts at addr 0.
